// File: rtl/instruction_fetch_pkg.sv
// Shared CPU definitions for the fetch stage.
// Covers instruction field widths, the HALT opcode, the NOP encoding, and the
// PC/instruction word types. It also provides a helper that extracts the opcode.
package instruction_fetch_pkg;

    localparam int OPC_W   = 5;
    localparam int IMM_W   = 4;
    localparam int INSTR_W = OPC_W + IMM_W;
    localparam int PC_W    = 16;

    localparam logic [OPC_W-1:0]   OP_HALT   = 5'b11010;
    localparam logic [INSTR_W-1:0] INSTR_NOP = '0;

    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] instr_t;

    // The opcode occupies the top OPC_W bits and the immediate fills the rest.
    function automatic logic [OPC_W-1:0] opcode_of(input instr_t instr);
        return instr[INSTR_W-1:IMM_W];
    endfunction

endpackage

// File: rtl/instruction_fetch_halt_ctrl.sv
// Halt controller for the fetch stage. It runs the RUN/DRAIN/HALTED FSM and
// its drain counter.
//   clk, reset     : clock, synchronous active-high reset
//   stall          : hold state and counter
//   redirect       : cancels a speculative halt (ignored once HALTED)
//   halt_fetch     : the current ROM word carries the HALT opcode
//   pc_freeze      : the PC must not advance this edge
//   inject_bubble  : IF/ID receives NOP/invalid instead of the ROM word
//   halted         : core has committed to halt
module fetch_halt_ctrl #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic stall,
    input  logic redirect,
    input  logic halt_fetch,
    output logic pc_freeze,
    output logic inject_bubble,
    output logic halted
);

    localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
            count <= '0;
        end else if (state == ST_HALTED) begin
            // Terminal state: only reset leaves it.
            state <= ST_HALTED;
        end else if (redirect) begin
            // A redirect resolved downstream means the HALT was on a wrong path.
            state <= ST_RUN;
            count <= '0;
        end else if (!stall) begin
            case (state)
                ST_RUN: begin
                    if (halt_fetch) begin
                        state <= ST_DRAIN;
                        count <= CNT_W'(DRAIN_CYCLES);
                    end
                end
                ST_DRAIN: begin
                    // The edge that takes the count to zero also commits the halt.
                    if (count <= CNT_W'(1)) begin
                        state <= ST_HALTED;
                        count <= '0;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_RUN;
                    count <= '0;
                end
            endcase
        end
    end

    assign halted        = (state == ST_HALTED);
    assign inject_bubble = (state == ST_DRAIN);
    // While in RUN, the PC holds on the HALT word itself, so the drained core parks on it.
    assign pc_freeze     = (state != ST_RUN) || halt_fetch;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage of the 9-bit-instruction pipelined CPU.
// It owns the PC, addresses the combinational ROM, and registers the returned
// word into the IF/ID latch for decode. It also handles stall, redirect and
// the halt drain.
//   clk, reset    : clock, synchronous active-high reset
//   stall         : hold PC and IF/ID
//   redirect      : taken branch/jump; redirect_pc is the new fetch address
//   rom_instr     : ROM word at pc (combinational)
//   pc            : fetch address
//   if_id_instr   : registered instruction to decode
//   if_id_pc      : PC of if_id_instr
//   if_id_valid   : 1 = real fetch, 0 = bubble
//   halted        : core has committed to halt
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0]    RESET_PC     = 16'd1,
    parameter int                 DRAIN_CYCLES = 3,
    parameter logic [INSTR_W-1:0] NOP_INSTR    = INSTR_NOP
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic [INSTR_W-1:0] rom_instr,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic               if_id_valid,
    output logic               halted
);

    logic halt_fetch;
    logic pc_freeze;
    logic inject_bubble;

    assign halt_fetch = (opcode_of(rom_instr) == OP_HALT);

    fetch_halt_ctrl #(
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) u_halt_ctrl (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .redirect      (redirect),
        .halt_fetch    (halt_fetch),
        .pc_freeze     (pc_freeze),
        .inject_bubble (inject_bubble),
        .halted        (halted)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
        end else if (halted) begin
            // Frozen: redirect and stall no longer matter.
            pc <= pc;
        end else if (redirect) begin
            // The word in flight belongs to the wrong path, so it is dropped.
            pc          <= redirect_pc;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            if (inject_bubble) begin
                if_id_instr <= NOP_INSTR;
                if_id_valid <= 1'b0;
            end else begin
                if_id_instr <= rom_instr;
                if_id_pc    <= pc;
                if_id_valid <= 1'b1;
                if (!pc_freeze)
                    pc <= pc + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'd0;
    logic [8:0]  rom_instr;
    logic [15:0] pc;
    logic [8:0]  if_id_instr;
    logic [15:0] if_id_pc;
    logic        if_id_valid;
    logic        halted;

    int checks = 0;
    int errors = 0;

    // ROM: pc-tagged words, with an optional HALT planted at halt_a.
    logic        halt_en = 1'b0;
    logic [15:0] halt_a  = 16'd0;

    // Reference model state: mode 0=fetching, 1=draining, 2=halted.
    logic [15:0] m_pc = 16'd1, m_ipc = 16'd0;
    logic [8:0]  m_instr = 9'h000;
    logic        m_valid = 1'b0;
    int          m_mode = 0, m_left = 0;

    instruction_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .rom_instr   (rom_instr),
        .pc          (pc),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_valid (if_id_valid),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] rom_word(input logic [15:0] a, input logic en,
                                            input logic [15:0] ha);
        logic [8:0] w;
        if (en && a == ha) return 9'b11010_0000;
        w = a[8:0];
        if (w[8:4] == 5'b11010) w[8] = 1'b0;
        return w;
    endfunction

    always_comb rom_instr = rom_word(pc, halt_en, halt_a);

    // One clock: drive inputs at the falling edge, then advance the model at the rising edge.
    task automatic cycle(input logic rst, input logic st, input logic rd, input logic [15:0] rpc);
        logic [8:0] w;
        @(negedge clk);
        reset = rst; stall = st; redirect = rd; redirect_pc = rpc;
        @(posedge clk);
        if (rst) begin
            m_pc = 16'd1; m_instr = 9'h000; m_ipc = 16'd0; m_valid = 1'b0; m_mode = 0; m_left = 0;
        end else if (m_mode == 2) begin
            m_mode = 2;
        end else if (rd) begin
            m_pc = rpc; m_instr = 9'h000; m_valid = 1'b0; m_mode = 0; m_left = 0;
        end else if (st) begin
            m_mode = m_mode;
        end else if (m_mode == 1) begin
            m_instr = 9'h000; m_valid = 1'b0; m_left = m_left - 1;
            if (m_left == 0) m_mode = 2;
        end else begin
            w = rom_word(m_pc, halt_en, halt_a);
            m_instr = w; m_ipc = m_pc; m_valid = 1'b1;
            if (w[8:4] == 5'b11010) begin m_mode = 1; m_left = 3; end
            else m_pc = m_pc + 16'd1;
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 16'd0);
        cycle(1, 1, 1, 16'h0033);
        checks++; if (pc !== 16'd1) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 16'd1); end
        checks++; if (if_id_instr !== 9'h000) begin errors++; $display("FAIL reset_instr got=%h exp=%h", if_id_instr, 9'h000); end
        checks++; if (if_id_pc !== 16'd0) begin errors++; $display("FAIL reset_ifid_pc got=%h exp=%h", if_id_pc, 16'd0); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", if_id_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
    endtask

    task automatic test_fetch();
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 16'd0);
            checks++; if (pc !== 16'(i + 2)) begin errors++; $display("FAIL fetch_pc got=%h exp=%h", pc, 16'(i + 2)); end
            checks++; if (if_id_pc !== 16'(i + 1)) begin errors++; $display("FAIL fetch_ifid_pc got=%h exp=%h", if_id_pc, 16'(i + 1)); end
            checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid got=%b exp=1", if_id_valid); end
            checks++; if (if_id_instr !== 9'(i + 1)) begin errors++; $display("FAIL fetch_instr got=%h exp=%h", if_id_instr, 9'(i + 1)); end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 16'd0);
            checks++; if (pc !== 16'd5 || if_id_pc !== 16'd4 || if_id_valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold got pc=%h ifid_pc=%h v=%b exp pc=0005 ifid_pc=0004 v=1", pc, if_id_pc, if_id_valid); end
        end
        cycle(0, 0, 0, 16'd0);
        checks++; if (pc !== 16'd6 || if_id_pc !== 16'd5) begin
            errors++; $display("FAIL stall_release got pc=%h ifid_pc=%h exp pc=0006 ifid_pc=0005", pc, if_id_pc); end
    endtask

    task automatic test_redirect_stall();
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 16'd0);
        cycle(0, 1, 1, 16'h000D);
        checks++; if (pc !== 16'd13) begin errors++; $display("FAIL redir_pc got=%h exp=%h", pc, 16'd13); end
        checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 9'h000) begin
            errors++; $display("FAIL redir_bubble got v=%b instr=%h exp v=0 instr=000", if_id_valid, if_id_instr); end
        cycle(0, 0, 0, 16'd0);
        checks++; if (if_id_pc !== 16'd13 || if_id_valid !== 1'b1 || pc !== 16'd14) begin
            errors++; $display("FAIL redir_resume got ifid_pc=%h v=%b pc=%h exp 000d 1 000e", if_id_pc, if_id_valid, pc); end
    endtask

    task automatic test_halt();
        halt_en = 1'b1; halt_a = 16'd14;
        cycle(0, 0, 0, 16'd0);
        checks++; if (if_id_instr !== 9'h1A0 || if_id_valid !== 1'b1 || pc !== 16'd14 || halted !== 1'b0) begin
            errors++; $display("FAIL halt_latch got instr=%h v=%b pc=%h h=%b exp 1a0 1 000e 0", if_id_instr, if_id_valid, pc, halted); end
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 16'd0);
            checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 9'h000 || pc !== 16'd14) begin
                errors++; $display("FAIL halt_bubble got v=%b instr=%h pc=%h exp 0 000 000e", if_id_valid, if_id_instr, pc); end
            checks++; if (halted !== (k == 2)) begin errors++; $display("FAIL halt_flag got=%b exp=%b", halted, (k == 2)); end
        end
        cycle(0, 1, 1, 16'h0020);
        cycle(0, 0, 1, 16'h0021);
        checks++; if (pc !== 16'd14 || halted !== 1'b1 || if_id_valid !== 1'b0) begin
            errors++; $display("FAIL halt_ignore got pc=%h h=%b v=%b exp 000e 1 0", pc, halted, if_id_valid); end
        cycle(1, 0, 0, 16'd0);
        halt_en = 1'b0;
        checks++; if (pc !== 16'd1 || halted !== 1'b0 || if_id_valid !== 1'b0) begin
            errors++; $display("FAIL reset_halted_state got pc=%h h=%b v=%b exp 0001 0 0", pc, halted, if_id_valid); end
        cycle(0, 0, 0, 16'd0);
        checks++; if (pc !== 16'd2 || if_id_pc !== 16'd1 || if_id_valid !== 1'b1) begin
            errors++; $display("FAIL reset_resume got pc=%h ifid_pc=%h v=%b exp 0002 0001 1", pc, if_id_pc, if_id_valid); end
    endtask

    task automatic test_cancel();
        halt_en = 1'b1; halt_a = 16'd8;
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 16'd0);
        cycle(0, 0, 0, 16'd0);
        cycle(0, 0, 0, 16'd0);
        cycle(0, 0, 1, 16'd3);
        halt_en = 1'b0;
        checks++; if (pc !== 16'd3 || halted !== 1'b0 || if_id_valid !== 1'b0) begin
            errors++; $display("FAIL cancel_redir got pc=%h h=%b v=%b exp 0003 0 0", pc, halted, if_id_valid); end
        cycle(0, 0, 0, 16'd0);
        checks++; if (pc !== 16'd4 || if_id_pc !== 16'd3 || if_id_valid !== 1'b1) begin
            errors++; $display("FAIL cancel_resume got pc=%h ifid_pc=%h v=%b exp 0004 0003 1", pc, if_id_pc, if_id_valid); end
        // A reset while draining also restarts cleanly.
        halt_en = 1'b1; halt_a = 16'd5;
        cycle(0, 0, 0, 16'd0);
        cycle(0, 0, 0, 16'd0);
        cycle(1, 0, 0, 16'd0);
        halt_en = 1'b0;
        checks++; if (pc !== 16'd1 || halted !== 1'b0 || if_id_valid !== 1'b0) begin
            errors++; $display("FAIL reset_drain got pc=%h h=%b v=%b exp 0001 0 0", pc, halted, if_id_valid); end
    endtask

    task automatic test_wrap();
        cycle(0, 0, 1, 16'h1234);
        cycle(0, 0, 1, 16'hFFFF);
        checks++; if (pc !== 16'hFFFF) begin errors++; $display("FAIL wrap_redir got=%h exp=ffff", pc); end
        cycle(0, 0, 0, 16'd0);
        checks++; if (pc !== 16'h0000 || if_id_pc !== 16'hFFFF || if_id_valid !== 1'b1) begin
            errors++; $display("FAIL wrap_pc got pc=%h ifid_pc=%h v=%b exp 0000 ffff 1", pc, if_id_pc, if_id_valid); end
    endtask

    task automatic test_random();
        logic rst, st, rd;
        logic [15:0] rpc;
        cycle(1, 0, 0, 16'd0);
        for (int i = 0; i < 500; i++) begin
            if (i % 40 == 0) begin
                halt_en = ($urandom_range(0, 2) != 0);
                halt_a  = 16'($urandom_range(2, 20));
            end
            rst = ($urandom_range(0, 39) == 0);
            st  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 7) == 0);
            rpc = ($urandom_range(0, 9) == 0) ? 16'(16'hFFFE + $urandom_range(0, 1)) : 16'($urandom_range(0, 24));
            cycle(rst, st, rd, rpc);
            checks++; if (pc !== m_pc) begin errors++; $display("FAIL rand_pc cyc=%0d got=%h exp=%h", i, pc, m_pc); end
            checks++; if (if_id_valid !== m_valid) begin errors++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", i, if_id_valid, m_valid); end
            checks++; if (if_id_instr !== m_instr) begin errors++; $display("FAIL rand_instr cyc=%0d got=%h exp=%h", i, if_id_instr, m_instr); end
            checks++; if (halted !== (m_mode == 2)) begin errors++; $display("FAIL rand_halted cyc=%0d got=%b exp=%b", i, halted, (m_mode == 2)); end
            if (m_valid) begin
                checks++; if (if_id_pc !== m_ipc) begin errors++; $display("FAIL rand_ifid_pc cyc=%0d got=%h exp=%h", i, if_id_pc, m_ipc); end
            end
        end
        halt_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_redirect_stall();
        test_halt();
        test_cancel();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
